ntsc_timing_gen: RTL and testbench

- Monochrome NTSC raster generator, directly downstream of the PLL/reset stage. Runs on the 16 MHz `clk` and the system `reset` produced there.
- Generates horizontal and vertical counters, sync, blanking and active-window timing for 262-line progressive ("240p") video.
- Requests pixels from an upstream pixel source and drives the 4-bit resistor-ladder DAC (`vdac`) with sync, blank or pixel levels.

---
 rtl/ntsc_timing_gen.sv | 163 ++++++++++++++++
 tb/tb_ntsc_timing_gen.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntsc_timing_gen.sv
// ntsc_timing_gen: monochrome 262-line progressive NTSC raster generator.
// Drives a 4-bit resistor-ladder DAC with sync, blank or pixel levels and
// requests pixels from an upstream source while inside the active window.
// Optional build macro NTSC_EQ_PULSES_EN replaces the broad vertical sync on
// lines 0-2 with an RS-170 style interval (equalizing + serrated vsync) on
// lines 0-8.
module ntsc_timing_gen #(
  parameter int         H_TOTAL     = 1016,
  parameter int         H_SYNC      = 75,
  parameter int         H_ACT_START = 160,
  parameter int         H_ACT_LEN   = 832,
  parameter int         V_TOTAL     = 262,
  parameter int         V_ACT_START = 21,
  parameter int         V_ACT_LEN   = 240,
  parameter logic [3:0] SYNC_LEVEL  = 4'd0,
  parameter logic [3:0] BLANK_LEVEL = 4'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] pix_data,
  output logic       pix_req,
  output logic [9:0] pix_x,
  output logic [8:0] pix_y,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic [3:0] vdac
);

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
  localparam logic [9:0] H_BROAD_END = 10'(H_TOTAL - H_SYNC);
  localparam logic [9:0] H_ACT_S     = 10'(H_ACT_START);
  localparam logic [9:0] H_ACT_E     = 10'(H_ACT_START + H_ACT_LEN);
  localparam logic [8:0] V_LAST      = 9'(V_TOTAL - 1);
  localparam logic [8:0] V_ACT_S     = 9'(V_ACT_START);
  localparam logic [8:0] V_ACT_E     = 9'(V_ACT_START + V_ACT_LEN);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [8:0] v_cnt_q, v_cnt_d;
  logic       h_last, v_last;
  logic       h_in_act, v_in_act, active;

  logic [3:0] vdac_q, vdac_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       frame_start_q, frame_start_d;
  logic [3:0] pix_level;

  // Vertical-interval decode: whether this line is in the interval, the
  // level it wants at the current h_cnt, and its vsync flag.
  logic       vert_int;
  logic [3:0] vert_level;
  logic       vert_vsync;

  // Counter next-state: explicit terminal compares, no reliance on overflow
  always_comb begin
    h_last  = (h_cnt_q == H_LAST);
    v_last  = (v_cnt_q == V_LAST);
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      h_cnt_d = '0;
      v_cnt_d = v_last ? '0 : v_cnt_q + 9'd1;
    end
  end

  // Active window and pixel coordinates, same cycle as the counters
  always_comb begin
    h_in_act = (h_cnt_q >= H_ACT_S) && (h_cnt_q < H_ACT_E);
    v_in_act = (v_cnt_q >= V_ACT_S) && (v_cnt_q < V_ACT_E);
    // Gating with reset keeps the request low the moment reset is seen,
    // before the counters have been cleared.
    active   = h_in_act && v_in_act && !reset;
    pix_req  = active;
    pix_x    = active ? (h_cnt_q - H_ACT_S) : '0;
    pix_y    = active ? (v_cnt_q - V_ACT_S) : '0;
  end

`ifdef NTSC_EQ_PULSES_EN
  localparam logic [9:0] H2         = 10'(H_TOTAL / 2);
  localparam logic [9:0] EQ_W       = 10'(H_SYNC / 2);
  localparam logic [9:0] H2_EQ_END  = 10'(H_TOTAL / 2 + H_SYNC / 2);
  localparam logic [9:0] H2_GAP_S   = 10'(H_TOTAL / 2 - H_SYNC);

  logic serr_gap;
  logic eq_pulse;

  // RS-170 interval: equalizing pulses on lines 0-2/6-8, serrated vsync on 3-5
  always_comb begin
    vert_int   = (v_cnt_q < 9'd9);
    vert_vsync = (v_cnt_q >= 9'd3) && (v_cnt_q <= 9'd5);
    serr_gap   = ((h_cnt_q >= H2_GAP_S) && (h_cnt_q < H2)) ||
                 (h_cnt_q >= H_BROAD_END);
    eq_pulse   = (h_cnt_q < EQ_W) ||
                 ((h_cnt_q >= H2) && (h_cnt_q < H2_EQ_END));
    if (vert_vsync) begin
      vert_level = serr_gap ? BLANK_LEVEL : SYNC_LEVEL;
    end else begin
      vert_level = eq_pulse ? SYNC_LEVEL : BLANK_LEVEL;
    end
  end

  // The equalizing interval occupies lines 0-8, so active video must start later
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (V_ACT_START >= 9)
        else $error("ntsc_timing_gen: V_ACT_START must be >= 9 with equalizing pulses");
    end
  end
`else
  // Broad-pulse vertical sync on lines 0-2: sync for most of the line
  always_comb begin
    vert_int   = (v_cnt_q < 9'd3);
    vert_vsync = vert_int;
    vert_level = (h_cnt_q < H_BROAD_END) ? SYNC_LEVEL : BLANK_LEVEL;
  end
`endif

  // Output level selection in priority order: vertical interval, hsync,
  // active pixel (clamped so dark codes never look like sync), blank
  always_comb begin
    vdac_d        = BLANK_LEVEL;
    hsync_d       = 1'b0;
    vsync_d       = 1'b0;
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    pix_level     = (pix_data < BLANK_LEVEL) ? BLANK_LEVEL : pix_data;
    if (vert_int) begin
      vdac_d  = vert_level;
      vsync_d = vert_vsync;
    end else if (h_cnt_q < H_SYNC_END) begin
      vdac_d  = SYNC_LEVEL;
      hsync_d = 1'b1;
    end else if (active) begin
      vdac_d  = pix_level;
    end
  end

  // State and registered outputs, synchronous reset aborts mid-line/frame
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      vdac_q        <= BLANK_LEVEL;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      vdac_q        <= vdac_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vdac        = vdac_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_ntsc_timing_gen.sv
// Testbench for ntsc_timing_gen using a reduced raster so whole frames fit in
// a short run. The reference model derives (h,v) from the cycle count since
// reset release and applies the output rules directly.
module tb_ntsc_timing_gen;

  localparam int HT    = 120;
  localparam int HS    = 10;
  localparam int HAS   = 20;
  localparam int HAL   = 76;
  localparam int VT    = 32;
  localparam int VAS   = 9;
  localparam int VAL   = 20;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] pix_data = 4'd0;
  logic       pix_req, hsync, vsync, frame_start;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic [3:0] vdac;

  int checks = 0;
  int errors = 0;

  int t = 0, cur_h = 0, cur_v = 0, prev_h = 0, prev_v = 0;
  logic [3:0] prev_pd = 4'd0;
  bit rst_edge = 1'b1;
  int mode = 0;

  ntsc_timing_gen #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HAS), .H_ACT_LEN(HAL),
    .V_TOTAL(VT), .V_ACT_START(VAS), .V_ACT_LEN(VAL)
  ) dut (
    .clk(clk), .reset(reset), .pix_data(pix_data), .pix_req(pix_req),
    .pix_x(pix_x), .pix_y(pix_y), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start), .vdac(vdac)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit m_window(int h, int v);
    return (h >= HAS) && (h < HAS + HAL) && (v >= VAS) && (v < VAS + VAL);
  endfunction

  function automatic logic [3:0] m_vdac(int h, int v, logic [3:0] pd);
`ifdef NTSC_EQ_PULSES_EN
    if (v < 9) begin
      if (v >= 3 && v <= 5)
        return ((h >= HT/2 - HS && h < HT/2) || h >= HT - HS) ? 4'd4 : 4'd0;
      return (h < HS/2 || (h >= HT/2 && h < HT/2 + HS/2)) ? 4'd0 : 4'd4;
    end
`else
    if (v < 3) return (h < HT - HS) ? 4'd0 : 4'd4;
`endif
    if (h < HS) return 4'd0;
    if (m_window(h, v)) return (pd < 4'd4) ? 4'd4 : pd;
    return 4'd4;
  endfunction

  function automatic bit m_hsync(int h, int v);
`ifdef NTSC_EQ_PULSES_EN
    return (v >= 9) && (h < HS);
`else
    return (v >= 3) && (h < HS);
`endif
  endfunction

  function automatic bit m_vsync(int v);
`ifdef NTSC_EQ_PULSES_EN
    return (v >= 3) && (v <= 5);
`else
    return v < 3;
`endif
  endfunction

  // expected values for the current cycle (registered ones from the last edge)
  function automatic logic [3:0] e_vdac();
    return rst_edge ? 4'd4 : m_vdac(prev_h, prev_v, prev_pd);
  endfunction
  function automatic bit e_hs(); return !rst_edge && m_hsync(prev_h, prev_v); endfunction
  function automatic bit e_vs(); return !rst_edge && m_vsync(prev_v); endfunction
  function automatic bit e_fs(); return !rst_edge && prev_h == 0 && prev_v == 0; endfunction
  function automatic bit e_req(); return !reset && m_window(cur_h, cur_v); endfunction
  function automatic logic [9:0] e_px(); return e_req() ? 10'(cur_h - HAS) : 10'd0; endfunction
  function automatic logic [8:0] e_py(); return e_req() ? 9'(cur_v - VAS) : 9'd0; endfunction

  // advance one clock, update model position, drive next pix_data
  task automatic tick();
    prev_h  = cur_h;
    prev_v  = cur_v;
    prev_pd = pix_data;
    @(posedge clk);
    rst_edge = reset;
    #1;
    t     = rst_edge ? 0 : t + 1;
    cur_h = t % HT;
    cur_v = (t / HT) % VT;
    case (mode)
      1:       pix_data = m_window(cur_h, cur_v) ? 4'(cur_h - HAS) : 4'($urandom_range(0, 15));
      2:       pix_data = 4'd15;
      default: pix_data = 4'($urandom_range(0, 15));
    endcase
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n;
    reset = 1'b1; mode = 0;
    repeat (3) tick();
    checks++; if (vdac !== 4'd4) begin errors++; $display("FAIL reset_vdac got %0d exp 4", vdac); end
    checks++; if ({hsync, vsync, frame_start, pix_req} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {hsync, vsync, frame_start, pix_req}); end
    reset = 1'b0;
    n = 0;
    while (!(cur_v == VAS + 2 && cur_h == HAS + 5) && n < 2 * FRAME) begin tick(); n++; end
    checks++; if (pix_req !== 1'b1 || n >= 2 * FRAME) begin
      errors++; $display("FAIL reset_midline_req got %b exp 1 (n=%0d)", pix_req, n); end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (vdac !== 4'd4 || pix_req !== 1'b0 || frame_start !== 1'b0 || hsync !== 1'b0 || vsync !== 1'b0) begin
        errors++; $display("FAIL reset_hold[%0d] vdac=%0d req=%b fs=%b hs=%b vs=%b exp 4/0/0/0/0",
                           i, vdac, pix_req, frame_start, hsync, vsync); end
    end
    reset = 1'b0;
    #1;
    checks++; if (pix_req !== 1'b0) begin errors++; $display("FAIL release_req got %b exp 0", pix_req); end
    tick();
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL release_fs got %b exp 1", frame_start); end
    checks++; if (vdac !== 4'd0) begin errors++; $display("FAIL release_vdac got %0d exp 0", vdac); end
    checks++; if (vsync !== m_vsync(0)) begin errors++; $display("FAIL release_vsync got %b exp %b", vsync, m_vsync(0)); end
    tick();
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL release_fs_width got %b exp 0", frame_start); end
  endtask

  task automatic test_free_run();
    int cyc = 0, last_fs = -1, req_cnt = 0, hs_cnt = 0, sync0_cnt = 0;
    bit counting = 0;
    int exp_hs, exp_sync0;
`ifdef NTSC_EQ_PULSES_EN
    exp_hs = (VT - 9) * HS; exp_sync0 = 2 * (HS / 2);
`else
    exp_hs = (VT - 3) * HS; exp_sync0 = HT - HS;
`endif
    mode = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick(); cyc++;
      checks++; if (vdac !== e_vdac()) begin errors++;
        if (errors <= 30) $display("FAIL run_vdac h=%0d v=%0d got %0d exp %0d", prev_h, prev_v, vdac, e_vdac()); end
      checks++; if (hsync !== e_hs()) begin errors++;
        if (errors <= 30) $display("FAIL run_hsync h=%0d v=%0d got %b exp %b", prev_h, prev_v, hsync, e_hs()); end
      checks++; if (vsync !== e_vs()) begin errors++;
        if (errors <= 30) $display("FAIL run_vsync v=%0d got %b exp %b", prev_v, vsync, e_vs()); end
      checks++; if (frame_start !== e_fs()) begin errors++;
        if (errors <= 30) $display("FAIL run_fs h=%0d v=%0d got %b exp %b", prev_h, prev_v, frame_start, e_fs()); end
      checks++; if (pix_req !== e_req() || pix_x !== e_px() || pix_y !== e_py()) begin errors++;
        if (errors <= 30) $display("FAIL run_pix h=%0d v=%0d got %b/%0d/%0d exp %b/%0d/%0d",
                                   cur_h, cur_v, pix_req, pix_x, pix_y, e_req(), e_px(), e_py()); end
      if (frame_start === 1'b1) begin
        if (counting) begin
          checks++; if (cyc - last_fs != FRAME) begin errors++; $display("FAIL fs_spacing got %0d exp %0d", cyc - last_fs, FRAME); end
          checks++; if (req_cnt != HAL * VAL) begin errors++; $display("FAIL req_per_frame got %0d exp %0d", req_cnt, HAL * VAL); end
          checks++; if (hs_cnt != exp_hs) begin errors++; $display("FAIL hsync_per_frame got %0d exp %0d", hs_cnt, exp_hs); end
          checks++; if (sync0_cnt != exp_sync0) begin errors++; $display("FAIL line0_sync got %0d exp %0d", sync0_cnt, exp_sync0); end
        end
        counting = 1; last_fs = cyc; req_cnt = 0; hs_cnt = 0; sync0_cnt = 0;
      end
      req_cnt   += int'(pix_req === 1'b1);
      hs_cnt    += int'(hsync === 1'b1);
      sync0_cnt += int'(prev_v == 0 && vdac === 4'd0);
    end
    checks++; if (last_fs < 0) begin errors++; $display("FAIL fs_seen got none exp pulse"); end
  endtask

  task automatic test_pixel_ramp();
    logic [3:0] exp;
    mode = 1;
    tick();
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (m_window(prev_h, prev_v)) begin
        exp = 4'(prev_h - HAS);
        if (exp < 4'd4) exp = 4'd4;
        checks++; if (vdac !== exp || vdac < 4'd4) begin errors++;
          if (errors <= 30) $display("FAIL ramp_vdac x=%0d got %0d exp %0d", prev_h - HAS, vdac, exp); end
      end
    end
    mode = 0;
  endtask

  task automatic test_white();
    int n = 0, white = 0, req = 0;
    mode = 2;
    while (!(cur_h == 0 && cur_v == 0) && n < 2 * FRAME) begin tick(); n++; end
    checks++; if (n >= 2 * FRAME) begin errors++; $display("FAIL white_align got timeout exp frame start"); end
    for (int i = 0; i < FRAME; i++) begin
      tick();
      white += int'(vdac === 4'd15);
      req   += int'(pix_req === 1'b1);
    end
    checks++; if (white != HAL * VAL) begin errors++; $display("FAIL white_count got %0d exp %0d", white, HAL * VAL); end
    checks++; if (req != HAL * VAL) begin errors++; $display("FAIL white_req got %0d exp %0d", req, HAL * VAL); end
    mode = 0;
  endtask

  task automatic test_boundaries();
    int n = 0;
    mode = 0;
    while (!(cur_h == HAS - 1 && cur_v == VAS) && n < 2 * FRAME) begin tick(); n++; end
    checks++; if (pix_req !== 1'b0 || n >= 2 * FRAME) begin errors++; $display("FAIL pre_window_req got %b exp 0", pix_req); end
    tick();
    checks++; if (pix_req !== 1'b1 || pix_x !== 10'd0 || pix_y !== 9'd0) begin errors++;
      $display("FAIL first_req got %b/%0d/%0d exp 1/0/0", pix_req, pix_x, pix_y); end
    n = 0;
    while (!(cur_h == HAS + HAL - 1 && cur_v == VAS + VAL - 1) && n < 2 * FRAME) begin tick(); n++; end
    checks++; if (pix_req !== 1'b1 || pix_x !== 10'(HAL - 1) || pix_y !== 9'(VAL - 1)) begin errors++;
      $display("FAIL last_req got %b/%0d/%0d exp 1/%0d/%0d", pix_req, pix_x, pix_y, HAL - 1, VAL - 1); end
    tick();
    checks++; if (pix_req !== 1'b0) begin errors++; $display("FAIL after_last_req got %b exp 0", pix_req); end
    n = 0;
    while (!(cur_h == HT - 1 && cur_v == VT - 1) && n < 2 * FRAME) begin tick(); n++; end
    checks++; if (vsync !== 1'b0 || n >= 2 * FRAME) begin errors++; $display("FAIL last_line_vsync got %b exp 0", vsync); end
    tick();
    tick();
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL wrap_fs got %b exp 1", frame_start); end
    checks++; if (vsync !== m_vsync(0)) begin errors++; $display("FAIL wrap_vsync got %b exp %b", vsync, m_vsync(0)); end
  endtask

  task automatic test_back_to_back();
    int gap;
    mode = 0;
    for (int k = 0; k < 2; k++) begin
      gap = $urandom_range(50, 2000);
      repeat (gap) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (vdac !== 4'd4 || frame_start !== 1'b0) begin errors++;
        $display("FAIL pulse_reset got vdac=%0d fs=%b exp 4/0", vdac, frame_start); end
      tick();
      checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL pulse_fs got %b exp 1", frame_start); end
      for (int i = 0; i < FRAME / 2; i++) begin
        tick();
        checks++; if (vdac !== e_vdac() || frame_start !== e_fs()) begin errors++;
          if (errors <= 30) $display("FAIL pulse_run h=%0d v=%0d got %0d/%b exp %0d/%b",
                                     prev_h, prev_v, vdac, frame_start, e_vdac(), e_fs()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_pixel_ramp();
    test_white();
    test_boundaries();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
